debug_streamer: RTL and testbench

Parametrised multi-channel debug frame transmitter. It snapshots `NUM_CHANNELS` words of `DATA_WIDTH` bits, either periodically or on demand, and serialises them MSB-first as bytes over a start/busy handshake. The handshake drives the existing `uart_tx` byte transmitter. It sits beside the display pipeline as the next-generation debug path, replacing the single-word, fixed-newline sender.

---
 rtl/debug_streamer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_debug_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_streamer.sv
// -----------------------------------------------------------------------------
// debug_streamer
//
// Multi-channel debug frame transmitter. On a request (manual trigger or the
// periodic auto tick) it snapshots NUM_CHANNELS words of DATA_WIDTH bits and
// serialises them, channel NUM_CHANNELS-1 first and most-significant part
// first, as bytes over a start/busy handshake to a uart_tx byte sender.
//
// Build option (macro DEBUG_STREAMER_HEX_EN):
//   defined   : ASCII hex frame. Each channel is DATA_WIDTH/4 uppercase hex
//               digits. Channels are separated by 0x20 and the frame ends
//               with 0x0A.
//   undefined : raw binary frame. Sync byte 0xA5, then DATA_WIDTH/8 bytes per
//               channel, with no separators and no terminator.
//
// Parameters:
//   DIVIDER_TICKS : auto-trigger period in clk_in cycles (>= 2)
//   DATA_WIDTH    : bits per channel (multiple of 8)
//   NUM_CHANNELS  : channel count (>= 1)
//
// Ports:
//   clk_in     in   clock
//   reset_n    in   synchronous active-low reset
//   enable     in   gates the periodic auto-trigger only
//   trigger    in   one-cycle manual frame request
//   data_in    in   NUM_CHANNELS*DATA_WIDTH, channel 0 in the LSBs
//   tx_busy    in   byte transmitter busy
//   tx_start   out  one-cycle byte-send pulse
//   tx_data    out  byte to send, valid while tx_start is high
//   busy       out  high from snapshot until the last byte completes
//   frame_done out  one-cycle pulse when the frame completes
//   dropped    out  saturating count of requests rejected while busy
// -----------------------------------------------------------------------------
module debug_streamer #(
   parameter int DIVIDER_TICKS = 67000000,
   parameter int DATA_WIDTH    = 16,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic                               clk_in,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic                               trigger,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
   input  logic                               tx_busy,
   output logic                               tx_start,
   output logic [7:0]                         tx_data,
   output logic                               busy,
   output logic                               frame_done,
   output logic [7:0]                         dropped
);

   localparam int CNT_W = $clog2(DIVIDER_TICKS);
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

`ifdef DEBUG_STREAMER_HEX_EN
   // Digits per channel; sub index UNITS is the separator/terminator slot.
   localparam int UNITS = DATA_WIDTH / 4;
`else
   // Raw bytes per channel.
   localparam int UNITS = DATA_WIDTH / 8;
`endif
   localparam int SUB_W = $clog2(UNITS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER_TICKS - 1);
   localparam logic [CH_W-1:0]  CH_TOP   = CH_W'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GUARD,
      S_WAIT
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]                   period_cnt;
   logic                               tick;
   logic                               req;

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] snapshot;
   logic [CH_W-1:0]                    chan_idx;
   logic [SUB_W-1:0]                   sub_idx;
`ifndef DEBUG_STREAMER_HEX_EN
   logic                               sync_pend;
`endif

   logic [DATA_WIDTH-1:0]              chan_word;
   logic [7:0]                         cur_byte;
   logic                               last_byte;

   logic                               load;
   logic                               send;
   logic                               advance;
   logic                               finish;
   logic                               drop;

   // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

   // ---------------------------------------------------------------------
   // Period counter: wraps every DIVIDER_TICKS cycles while enabled; the
   // wrap cycle is the auto tick.
   // ---------------------------------------------------------------------
   assign tick = enable && (period_cnt == CNT_LAST);
   assign req  = trigger | tick;

   always_ff @(posedge clk_in) begin
      if (!reset_n || !enable) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Byte selection from the frozen snapshot.
   // ---------------------------------------------------------------------
   assign chan_word = snapshot[int'(chan_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef DEBUG_STREAMER_HEX_EN
   assign last_byte = (chan_idx == '0) && (sub_idx == SUB_W'(UNITS));

   always_comb begin
      cur_byte = 8'h00;
      if (sub_idx == SUB_W'(UNITS)) begin
         cur_byte = (chan_idx == '0) ? 8'h0A : 8'h20;
      end else begin
         cur_byte = hex_ascii(4'(chan_word >> (4 * (UNITS - 1 - int'(sub_idx)))));
      end
   end
`else
   assign last_byte = !sync_pend && (chan_idx == '0) && (sub_idx == SUB_W'(UNITS - 1));

   always_comb begin
      cur_byte = 8'h00;
      if (sync_pend) begin
         cur_byte = 8'hA5;
      end else begin
         cur_byte = 8'(chan_word >> (8 * (UNITS - 1 - int'(sub_idx))));
      end
   end
`endif

   // ---------------------------------------------------------------------
   // FSM: state register and next-state / control decode.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      send       = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               load       = 1'b1;
               state_next = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               send       = 1'b1;
               state_next = S_GUARD;
            end
         end
         // uart_tx raises busy one edge after seeing tx_start; this cycle
         // keeps WAIT from mistaking the pre-assertion low for completion.
         S_GUARD: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (!tx_busy) begin
               advance = 1'b1;
               if (last_byte) begin
                  finish     = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  state_next = S_SEND;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      // Requests outside IDLE are rejected, never queued.
      drop = req && (state != S_IDLE);
   end

   assign busy = (state != S_IDLE);

   // ---------------------------------------------------------------------
   // Registered handshake outputs, indices and drop counter.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         frame_done <= 1'b0;
         dropped    <= 8'h00;
         chan_idx   <= '0;
         sub_idx    <= '0;
`ifndef DEBUG_STREAMER_HEX_EN
         sync_pend  <= 1'b0;
`endif
      end else begin
         tx_start   <= send;
         frame_done <= finish;
         if (send) begin
            tx_data <= cur_byte;
         end
         if (drop && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
         end
         if (load) begin
            chan_idx  <= CH_TOP;
            sub_idx   <= '0;
`ifndef DEBUG_STREAMER_HEX_EN
            sync_pend <= 1'b1;
`endif
         end else if (advance) begin
`ifdef DEBUG_STREAMER_HEX_EN
            if (sub_idx == SUB_W'(UNITS)) begin
               sub_idx  <= '0;
               chan_idx <= chan_idx - CH_W'(1);
            end else begin
               sub_idx <= sub_idx + SUB_W'(1);
            end
`else
            if (sync_pend) begin
               sync_pend <= 1'b0;
            end else if (sub_idx == SUB_W'(UNITS - 1)) begin
               sub_idx  <= '0;
               chan_idx <= chan_idx - CH_W'(1);
            end else begin
               sub_idx <= sub_idx + SUB_W'(1);
            end
`endif
         end
      end
   end

   // Snapshot is data only; it is meaningful only once loaded.
   always_ff @(posedge clk_in) begin
      if (load) begin
         snapshot <= data_in;
      end
   end

endmodule

// File: tb/tb_debug_streamer.sv
module tb_debug_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        enable1, enable2;
   logic        trigger1, trigger2;
   logic        hold;
   logic [31:0] data1;
   logic [7:0]  data2;
   logic        tx_busy1;
   logic        tx_busy2;
   logic        tx_start1, tx_start2;
   logic [7:0]  tx_data1, tx_data2;
   logic        busy1, busy2;
   logic        frame_done1, frame_done2;
   logic [7:0]  dropped1, dropped2;

   int checks   = 0;
   int failures = 0;

`ifdef DEBUG_STREAMER_HEX_EN
   localparam int FLEN1 = 10;
   localparam int FLEN2 = 3;
   logic [7:0] exp1 [FLEN1] = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h20,
                                8'h30, 8'h30, 8'h46, 8'h30, 8'h0A};
   logic [7:0] exp2 [FLEN2] = '{8'h43, 8'h33, 8'h0A};
`else
   localparam int FLEN1 = 5;
   localparam int FLEN2 = 2;
   logic [7:0] exp1 [FLEN1] = '{8'hA5, 8'h12, 8'hAB, 8'h00, 8'hF0};
   logic [7:0] exp2 [FLEN2] = '{8'hA5, 8'hC3};
`endif

   debug_streamer #(.DIVIDER_TICKS(10), .DATA_WIDTH(16), .NUM_CHANNELS(2)) dut1 (
      .clk_in(clk), .reset_n(reset_n), .enable(enable1), .trigger(trigger1),
      .data_in(data1), .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1),
      .busy(busy1), .frame_done(frame_done1), .dropped(dropped1));

   debug_streamer #(.DIVIDER_TICKS(10), .DATA_WIDTH(8), .NUM_CHANNELS(1)) dut2 (
      .clk_in(clk), .reset_n(reset_n), .enable(enable2), .trigger(trigger2),
      .data_in(data2), .tx_busy(tx_busy2), .tx_start(tx_start2), .tx_data(tx_data2),
      .busy(busy2), .frame_done(frame_done2), .dropped(dropped2));

   // uart_tx model for dut1: busy for busy_len cycles after each start.
   int busy_len = 5;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start1) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy1 = hold || (busy_cnt != 0);

   // Observation state, updated only from the stimulus process.
   logic [7:0] bytes1[$];
   logic [7:0] bytes2[$];
   int         rises[$];
   int         cyc = 0;
   int         starts1 = 0;
   int         fd1 = 0;
   int         dbl = 0;
   logic       prev1 = 1'b0;
   logic       prev_busy2 = 1'b0;

   task automatic step();
      @(negedge clk);
      cyc++;
      if (tx_start1) begin
         bytes1.push_back(tx_data1);
         starts1++;
         if (prev1) dbl++;
      end
      prev1 = tx_start1;
      if (frame_done1) fd1++;
      if (tx_start2) bytes2.push_back(tx_data2);
      if (busy2 && !prev_busy2) rises.push_back(cyc);
      prev_busy2 = busy2;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_start"}, {31'd0, tx_start1}, 32'd0);
      chk({tag, "_tx_data"}, {24'd0, tx_data1}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
      chk({tag, "_frame_done"}, {31'd0, frame_done1}, 32'd0);
      chk({tag, "_dropped"}, {24'd0, dropped1}, 32'd0);
   endtask

   task automatic wait_done(input string tag, input int bound);
      int   n0;
      logic seen;
      logic busy_at;
      n0 = fd1;
      seen = 1'b0;
      busy_at = 1'b1;
      for (int i = 0; i < bound && !seen; i++) begin
         step();
         if (fd1 != n0) begin
            seen = 1'b1;
            busy_at = busy1;
         end
      end
      chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_busy_at_done"}, {31'd0, busy_at}, 32'd0);
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] got;
      chk({tag, "_len"}, bytes1.size(), FLEN1);
      for (int i = 0; i < FLEN1; i++) begin
         got = (i < bytes1.size()) ? bytes1[i] : 8'hxx;
         chk($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp1[i]});
      end
   endtask

   initial begin
      int s0;
      int f0;
      int c_en;
      int n;
      logic reached;

      reset_n  = 1'b0;
      enable1  = 1'b0;
      enable2  = 1'b0;
      trigger1 = 1'b0;
      trigger2 = 1'b0;
      hold     = 1'b0;
      tx_busy2 = 1'b0;
      data1    = 32'h12AB_00F0;
      data2    = 8'hC3;

      // Reset state
      steps(3);
      chk_reset("rst0");
      reset_n = 1'b1;
      steps(2);

      // Single triggered frame, 5-cycle transmitter
      bytes1.delete();
      f0 = fd1;
      trigger1 = 1'b1;
      step();
      trigger1 = 1'b0;
      chk("lat_busy", {31'd0, busy1}, 32'd1);
      chk("lat_no_start", {31'd0, tx_start1}, 32'd0);
      step();
      chk("first_start", {31'd0, tx_start1}, 32'd1);
      chk("first_data", {24'd0, tx_data1}, {24'd0, exp1[0]});
      wait_done("frame1", 300);
      steps(3);
      check_frame("frame1");
      chk("frame1_done_count", fd1 - f0, 32'd1);
      chk("frame1_dropped", {24'd0, dropped1}, 32'd0);

      // Overrun: three requests during one frame, data changes after latch
      bytes1.delete();
      trigger1 = 1'b1;
      step();
      trigger1 = 1'b0;
      data1 = 32'hFFFF_FFFF;
      step();
      for (int k = 0; k < 3; k++) begin
         trigger1 = 1'b1;
         step();
         trigger1 = 1'b0;
         step();
      end
      chk("ovr_dropped", {24'd0, dropped1}, 32'd3);
      wait_done("ovr", 300);
      step();
      check_frame("ovr");

      // Backpressure plus dropped saturation
      data1 = 32'h12AB_00F0;
      bytes1.delete();
      s0 = starts1;
      hold = 1'b1;
      trigger1 = 1'b1;
      steps(300);
      trigger1 = 1'b0;
      chk("bp_no_start", starts1 - s0, 32'd0);
      chk("sat_dropped", {24'd0, dropped1}, 32'd255);
      chk("bp_busy", {31'd0, busy1}, 32'd1);
      hold = 1'b0;
      step();
      chk("bp_start_after", {31'd0, tx_start1}, 32'd1);
      chk("bp_one_start", starts1 - s0, 32'd1);
      wait_done("bp", 300);
      step();
      check_frame("bp");

      // Reset after the third byte of a frame
      bytes1.delete();
      s0 = starts1;
      trigger1 = 1'b1;
      step();
      trigger1 = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         step();
         if (starts1 - s0 >= 3) reached = 1'b1;
      end
      chk("rst_third_byte", {31'd0, reached}, 32'd1);
      reset_n = 1'b0;
      step();
      chk_reset("rst_mid");
      reset_n = 1'b1;
      steps(2);
      bytes1.delete();
      trigger1 = 1'b1;
      step();
      trigger1 = 1'b0;
      wait_done("rst_new", 300);
      step();
      check_frame("rst_new");

      // Periodic frames on the small instance, instant transmitter
      rises.delete();
      bytes2.delete();
      enable2 = 1'b1;
      c_en = cyc;
      steps(35);
      chk("per_rises", (rises.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (rises.size() >= 3) begin
         chk("per_first", rises[0] - c_en, 32'd10);
         chk("per_gap1", rises[1] - rises[0], 32'd10);
         chk("per_gap2", rises[2] - rises[1], 32'd10);
      end
      chk("per_bytes", (bytes2.size() >= FLEN2) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < FLEN2; i++) begin
         chk($sformatf("per_b%0d", i),
             {24'd0, (i < bytes2.size()) ? bytes2[i] : 8'hxx}, {24'd0, exp2[i]});
      end
      chk("per_dropped", {24'd0, dropped2}, 32'd0);
      enable2 = 1'b0;
      steps(12);
      n = rises.size();
      steps(25);
      chk("dis_no_auto", rises.size(), n);
      trigger2 = 1'b1;
      step();
      trigger2 = 1'b0;
      chk("dis_trig_busy", {31'd0, busy2}, 32'd1);
      chk("dis_trig_rise", rises.size(), n + 1);

      chk("start_never_double", dbl, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
